// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives hazard sources). slave: hazard_ctrl side.
interface hazard_ctrl_if;
  logic [4:0]  rf_ra0_id, rf_ra1_id;
  logic        rf_re0_id, rf_re1_id;
  logic [4:0]  rf_ra0_ex, rf_ra1_ex;
  logic        rf_re0_ex, rf_re1_ex;
  logic [4:0]  rf_wa_ex, rf_wa_mem, rf_wa_wb;
  logic        rf_we_ex, rf_we_mem, rf_we_wb;
  logic [1:0]  rf_wd_sel_ex;
  logic [1:0]  pc_sel_ex;
  logic        dm_req_mem;
  logic        dm_ack;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex, flush_mem_wb;
  logic [1:0]  fwd0_sel, fwd1_sel;
  logic        err;
  logic [31:0] cnt_stall, cnt_flush;

  modport master (
    output rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
           rf_ra0_ex, rf_ra1_ex, rf_re0_ex, rf_re1_ex,
           rf_wa_ex, rf_wa_mem, rf_wa_wb, rf_we_ex, rf_we_mem, rf_we_wb,
           rf_wd_sel_ex, pc_sel_ex, dm_req_mem, dm_ack,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb,
           fwd0_sel, fwd1_sel, err, cnt_stall, cnt_flush
  );

  modport slave (
    input  rf_ra0_id, rf_ra1_id, rf_re0_id, rf_re1_id,
           rf_ra0_ex, rf_ra1_ex, rf_re0_ex, rf_re1_ex,
           rf_wa_ex, rf_wa_mem, rf_wa_wb, rf_we_ex, rf_we_mem, rf_we_wb,
           rf_wd_sel_ex, pc_sel_ex, dm_req_mem, dm_ack,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb,
           fwd0_sel, fwd1_sel, err, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stalls, flushes, forwarding, memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [1:0]  LOAD_SEL    = 2'b01
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  localparam logic [15:0] Timeout = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic mem_hold, redirect, load_use, redirect_flush;

  function automatic logic [1:0] fwd_sel(input logic re, input logic [4:0] ra,
                                         input logic we_mem, input logic [4:0] wa_mem,
                                         input logic we_wb, input logic [4:0] wa_wb);
    if (!re || ra == 5'd0)            return 2'b00;
    else if (we_mem && wa_mem == ra)  return 2'b01;
    else if (we_wb && wa_wb == ra)    return 2'b10;
    else                              return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        wait_cnt_d = 16'd0;
        if (hz.dm_req_mem && !hz.dm_ack) begin
          state_d    = StMemWait;
          wait_cnt_d = 16'd1;
        end
      end
      StMemWait: begin
        if (hz.dm_ack) begin
          state_d    = StRun;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == Timeout) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StErr: ;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    mem_hold = (state_q == StErr)
             || (state_q == StMemWait && !hz.dm_ack)
             || (state_q == StRun && hz.dm_req_mem && !hz.dm_ack);
    redirect = (hz.pc_sel_ex != 2'b00);
    load_use = hz.rf_we_ex && (hz.rf_wd_sel_ex == LOAD_SEL) && (hz.rf_wa_ex != 5'd0)
             && ((hz.rf_re0_id && hz.rf_ra0_id == hz.rf_wa_ex)
              || (hz.rf_re1_id && hz.rf_ra1_id == hz.rf_wa_ex));
    redirect_flush = !rst && !mem_hold && redirect;

    hz.stall_pc     = 1'b0;
    hz.stall_if_id  = 1'b0;
    hz.stall_id_ex  = 1'b0;
    hz.stall_ex_mem = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.flush_mem_wb = 1'b0;
    hz.fwd0_sel     = 2'b00;
    hz.fwd1_sel     = 2'b00;
    hz.err          = 1'b0;

    if (rst) begin
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_mem_wb = 1'b1;
    end else begin
      hz.fwd0_sel = fwd_sel(hz.rf_re0_ex, hz.rf_ra0_ex, hz.rf_we_mem, hz.rf_wa_mem,
                            hz.rf_we_wb, hz.rf_wa_wb);
      hz.fwd1_sel = fwd_sel(hz.rf_re1_ex, hz.rf_ra1_ex, hz.rf_we_mem, hz.rf_wa_mem,
                            hz.rf_we_wb, hz.rf_wa_wb);
      hz.err      = (state_q == StErr);
      if (mem_hold) begin
        hz.stall_pc     = 1'b1;
        hz.stall_if_id  = 1'b1;
        hz.stall_id_ex  = 1'b1;
        hz.stall_ex_mem = 1'b1;
        hz.flush_mem_wb = 1'b1;
      end else if (redirect) begin
        // The ID instruction is squashed, so a pending load-use stall is moot.
        hz.flush_if_id = 1'b1;
        hz.flush_id_ex = 1'b1;
      end else if (load_use) begin
        hz.stall_pc    = 1'b1;
        hz.stall_if_id = 1'b1;
        hz.flush_id_ex = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_stall_q, cnt_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_stall_q <= 32'd0;
      cnt_flush_q <= 32'd0;
    end else begin
      if (hz.stall_pc)    cnt_stall_q <= cnt_stall_q + 32'd1;
      if (redirect_flush) cnt_flush_q <= cnt_flush_q + 32'd1;
    end
  end

  assign hz.cnt_stall = cnt_stall_q;
  assign hz.cnt_flush = cnt_flush_q;
`else
  logic unused_redirect_flush;
  assign unused_redirect_flush = redirect_flush;
  assign hz.cnt_stall = 32'd0;
  assign hz.cnt_flush = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int unsigned To = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MEM_TIMEOUT(To), .LOAD_SEL(2'b01)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: waiting flag, cycles waited, sticky error, counter images.
  bit          m_wait, m_err;
  int          m_waited;
  logic [31:0] m_cs, m_cf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic re, input logic [4:0] ra);
    if (!re || ra == 0) return 2'b00;
    if (bus.rf_we_mem && bus.rf_wa_mem == ra) return 2'b01;
    if (bus.rf_we_wb && bus.rf_wa_wb == ra) return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    bus.rf_ra0_id = 0; bus.rf_ra1_id = 0; bus.rf_re0_id = 0; bus.rf_re1_id = 0;
    bus.rf_ra0_ex = 0; bus.rf_ra1_ex = 0; bus.rf_re0_ex = 0; bus.rf_re1_ex = 0;
    bus.rf_wa_ex = 0; bus.rf_wa_mem = 0; bus.rf_wa_wb = 0;
    bus.rf_we_ex = 0; bus.rf_we_mem = 0; bus.rf_we_wb = 0;
    bus.rf_wd_sel_ex = 0; bus.pc_sel_ex = 0; bus.dm_req_mem = 0; bus.dm_ack = 0;
  endtask

  task automatic randomize_inputs();
    bus.rf_ra0_id = 5'($urandom_range(0, 3)); bus.rf_ra1_id = 5'($urandom_range(0, 3));
    bus.rf_re0_id = 1'($urandom);            bus.rf_re1_id = 1'($urandom);
    bus.rf_ra0_ex = 5'($urandom_range(0, 3)); bus.rf_ra1_ex = 5'($urandom_range(0, 3));
    bus.rf_re0_ex = 1'($urandom);            bus.rf_re1_ex = 1'($urandom);
    bus.rf_wa_ex  = 5'($urandom_range(0, 3)); bus.rf_wa_mem = 5'($urandom_range(0, 3));
    bus.rf_wa_wb  = 5'($urandom_range(0, 3));
    bus.rf_we_ex  = 1'($urandom); bus.rf_we_mem = 1'($urandom); bus.rf_we_wb = 1'($urandom);
    bus.rf_wd_sel_ex = 2'($urandom);
    bus.pc_sel_ex  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    bus.dm_req_mem = 1'($urandom);
    bus.dm_ack     = ($urandom_range(0, 2) == 0);
    rst            = ($urandom_range(0, 24) == 0);
  endtask

  // Checks one cycle of outputs against the model, then advances the model over the edge.
  task automatic cycle();
    bit hold, redir, lu;
    logic [6:0] ev;
    #4;
    hold  = m_err || (m_wait && !bus.dm_ack) || (!m_wait && bus.dm_req_mem && !bus.dm_ack);
    redir = (bus.pc_sel_ex != 0);
    lu    = bus.rf_we_ex && bus.rf_wd_sel_ex == 2'b01 && bus.rf_wa_ex != 0
         && ((bus.rf_re0_id && bus.rf_ra0_id == bus.rf_wa_ex)
          || (bus.rf_re1_id && bus.rf_ra1_id == bus.rf_wa_ex));
    if (rst)        ev = 7'b0000111;
    else if (hold)  ev = 7'b1111001;
    else if (redir) ev = 7'b0000110;
    else if (lu)    ev = 7'b1100010;
    else            ev = 7'b0000000;
    check("ctl", 32'({bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                      bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb}), 32'(ev));
    check("fwd0", 32'(bus.fwd0_sel), rst ? 32'd0 : 32'(exp_fwd(bus.rf_re0_ex, bus.rf_ra0_ex)));
    check("fwd1", 32'(bus.fwd1_sel), rst ? 32'd0 : 32'(exp_fwd(bus.rf_re1_ex, bus.rf_ra1_ex)));
    check("err", 32'(bus.err), 32'(m_err && !rst));
`ifdef HAZARD_PERF_CNT_EN
    check("cnt_stall", bus.cnt_stall, m_cs);
    check("cnt_flush", bus.cnt_flush, m_cf);
`else
    check("cnt_stall", bus.cnt_stall, 32'd0);
    check("cnt_flush", bus.cnt_flush, 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_err = 0; m_waited = 0; m_cs = 0; m_cf = 0;
    end else begin
      m_cs = m_cs + 32'(ev[6]);
      m_cf = m_cf + 32'(!hold && redir);
      if (m_err) begin
      end else if (m_wait) begin
        if (bus.dm_ack) begin m_wait = 0; m_waited = 0; end
        else if (m_waited == int'(To)) m_err = 1;
        else m_waited++;
      end else if (bus.dm_req_mem && !bus.dm_ack) begin
        m_wait = 1; m_waited = 1;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] cf0;
    m_wait = 0; m_err = 0; m_waited = 0; m_cs = 0; m_cf = 0;
    idle();
    rst = 1;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;
    cycle();

    // Load-use on ra1, then bubble in EX, then load to x0.
    bus.rf_we_ex = 1; bus.rf_wd_sel_ex = 2'b01; bus.rf_wa_ex = 5; bus.rf_ra1_id = 5;
    bus.rf_re1_id = 1;
    cycle();
    bus.rf_we_ex = 0;
    cycle();
    bus.rf_we_ex = 1; bus.rf_wa_ex = 0; bus.rf_ra1_id = 0;
    cycle();
    idle();

    // Forwarding priority and x0.
    bus.rf_we_mem = 1; bus.rf_wa_mem = 7; bus.rf_we_wb = 1; bus.rf_wa_wb = 7;
    bus.rf_re0_ex = 1; bus.rf_ra0_ex = 7;
    #1 check("fwd_mem", 32'(bus.fwd0_sel), 32'd1);
    cycle();
    bus.rf_we_mem = 0;
    #1 check("fwd_wb", 32'(bus.fwd0_sel), 32'd2);
    cycle();
    bus.rf_ra0_ex = 0; bus.rf_wa_wb = 0; bus.rf_wa_mem = 0;
    cycle();
    idle();

    // Redirect together with load-use.
    cf0 = bus.cnt_flush;
    bus.rf_we_ex = 1; bus.rf_wd_sel_ex = 2'b01; bus.rf_wa_ex = 5; bus.rf_ra0_id = 5;
    bus.rf_re0_id = 1; bus.pc_sel_ex = 2'b01;
    #1 check("redir_stall_pc", 32'(bus.stall_pc), 32'd0);
    cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("redir_cnt_flush", bus.cnt_flush, cf0 + 32'd1);
`else
    check("redir_cnt_flush", bus.cnt_flush, cf0);
`endif
    idle();

    // Memory wait: three held cycles, release on ack.
    rst = 1; cycle(); rst = 0;
    bus.dm_req_mem = 1;
    repeat (3) cycle();
    bus.dm_ack = 1;
    cycle();
    idle();
    cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("memwait_cnt_stall", bus.cnt_stall, 32'd3);
`else
    check("memwait_cnt_stall", bus.cnt_stall, 32'd0);
`endif

    // Timeout into sticky error, cleared by a single reset cycle.
    bus.dm_req_mem = 1;
    repeat (6) cycle();
    check("timeout_err", 32'(bus.err), 32'd1);
    idle();
    cycle();
    rst = 1; cycle(); rst = 0;
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_cnt_stall", bus.cnt_stall, 32'd0);
    cycle();

    repeat (2000) begin
      randomize_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
